// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Decode-stage issue gate. Tracks which architectural registers have a
//   long-latency result (MUL/DIV/REM, loads) still outstanding, and holds the
//   decoder off on RAW/WAW hazards, on a full in-flight table, and while a
//   fence waits for outstanding long ops to drain.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue; ready follows the hazard checks
//   DRAIN | a fence is waiting for every long op to write back; ready=0
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   dec_valid_i          decoder presents an instruction
//   dec_ready_o          instruction accepted this cycle (combinational)
//   rs1/rs2_addr_i/read  source indices and their read enables
//   rd_addr_i            destination index, reg_write_i = writes rd
//   long_op_i            multi-cycle op, completes through wb_valid_i
//   fence_i              instruction waits for zero outstanding long ops
//   flush_i              squash the decode-stage instruction
//   wb_valid_i/addr_i    long-op writeback
//   issue_o, stall_o     handshake outcome (combinational)
//   inflight_o           outstanding long-op count
//   busy_o               per-register busy scoreboard, bit 0 always 0
//   err_o                sticky: writeback to a register that was not busy
module issue_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dec_valid_i,
    output logic                dec_ready_o,
    input  logic [4:0]          rs1_addr_i,
    input  logic                rs1_read_i,
    input  logic [4:0]          rs2_addr_i,
    input  logic                rs2_read_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                reg_write_i,
    input  logic                long_op_i,
    input  logic                fence_i,
    input  logic                flush_i,
    input  logic                wb_valid_i,
    input  logic [4:0]          wb_addr_i,
    output logic                issue_o,
    output logic                stall_o,
    output logic [CNT_W-1:0]    inflight_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                err_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic                err_q, err_d;

    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] eb;
    logic                wb_cnt;
    logic                raw_haz, waw_haz, full_haz;
    logic [CNT_W-1:0]    inflight_next_wb;
    logic                fence_wait;
    logic                ready;
    logic                issue_int;

    // A writeback in this cycle frees its register for the instruction in decode.
    assign wb_hit = wb_valid_i ? (NUM_REGS'(1) << wb_addr_i) : '0;
    assign eb     = busy_q & ~wb_hit;
    // Only a writeback to a busy register retires an in-flight op.
    assign wb_cnt = wb_valid_i & busy_q[wb_addr_i];

    assign raw_haz = (rs1_read_i & eb[rs1_addr_i]) | (rs2_read_i & eb[rs2_addr_i]);
    assign waw_haz = reg_write_i & eb[rd_addr_i];
    // The freed slot must come from a retiring op; an erroneous writeback
    // frees nothing, so relying on it could push the count past MAX.
    assign full_haz = long_op_i & (inflight_q == CNT_W'(MAX_INFLIGHT)) & ~wb_cnt;

    assign inflight_next_wb = inflight_q - CNT_W'(wb_cnt);
    assign fence_wait       = fence_i & (inflight_next_wb != '0);

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_RUN: begin
                ready = ~(raw_haz | waw_haz | full_haz | fence_wait);
                if (dec_valid_i && !flush_i && fence_wait) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush_i || (inflight_q == '0) ||
                    ((inflight_q == CNT_W'(1)) && wb_cnt)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign issue_int = dec_valid_i & ready & ~flush_i;

    // Reset gating only shapes the handshake outputs; flops are held by the
    // async reset anyway.
    assign dec_ready_o = ready & rst_i;
    assign issue_o     = issue_int & rst_i;
    assign stall_o     = rst_i ? (dec_valid_i & ~ready & ~flush_i) : dec_valid_i;

    always_comb begin
        // Clear the retiring register first so a same-cycle issue to the
        // same rd leaves it busy for the new op.
        busy_d = busy_q & ~wb_hit;
        if (issue_int && long_op_i && reg_write_i && (rd_addr_i != 5'd0)) begin
            busy_d[rd_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        inflight_d = inflight_q + CNT_W'(issue_int & long_op_i) - CNT_W'(wb_cnt);
        err_d      = err_q | (wb_valid_i & ~busy_q[wb_addr_i]);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            busy_q     <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight_o = inflight_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard
//   Directed bench for issue_scoreboard. Inputs change 1 ns after a rising
//   edge; combinational outputs are checked 1 ns later, registered outputs
//   after the following edge.
module tb_issue_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [4:0]  rs1_addr_i;
    logic        rs1_read_i;
    logic [4:0]  rs2_addr_i;
    logic        rs2_read_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i;
    logic        long_op_i;
    logic        fence_i;
    logic        flush_i;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic        issue_o;
    logic        stall_o;
    logic [2:0]  inflight_o;
    logic [31:0] busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    issue_scoreboard #(.NUM_REGS(32), .MAX_INFLIGHT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dec_valid_i (dec_valid_i),
        .dec_ready_o (dec_ready_o),
        .rs1_addr_i  (rs1_addr_i),
        .rs1_read_i  (rs1_read_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs2_read_i  (rs2_read_i),
        .rd_addr_i   (rd_addr_i),
        .reg_write_i (reg_write_i),
        .long_op_i   (long_op_i),
        .fence_i     (fence_i),
        .flush_i     (flush_i),
        .wb_valid_i  (wb_valid_i),
        .wb_addr_i   (wb_addr_i),
        .issue_o     (issue_o),
        .stall_o     (stall_o),
        .inflight_o  (inflight_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dec_valid_i = 1'b0; rs1_addr_i = '0; rs1_read_i = 1'b0;
        rs2_addr_i  = '0;   rs2_read_i = 1'b0; rd_addr_i = '0;
        reg_write_i = 1'b0; long_op_i  = 1'b0; fence_i   = 1'b0;
        flush_i     = 1'b0; wb_valid_i = 1'b0; wb_addr_i = '0;
    endtask

    task automatic long_op(input logic [4:0] rd);
        idle();
        dec_valid_i = 1'b1; rd_addr_i = rd; reg_write_i = 1'b1; long_op_i = 1'b1;
    endtask

    task automatic writeback(input logic [4:0] addr);
        idle();
        wb_valid_i = 1'b1; wb_addr_i = addr;
    endtask

    task automatic fence_instr();
        idle();
        dec_valid_i = 1'b1; fence_i = 1'b1;
    endtask

    task automatic pulse_reset();
        idle();
        #2 rst_i = 1'b0;
        #2 rst_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b0;
        dec_valid_i = 1'b1;
        #1;
        n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", dec_ready_o); end
        n_checks++; if (issue_o !== 1'b0) begin n_fail++; $display("FAIL reset_issue got %b want 0", issue_o); end
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", stall_o); end
        n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy_o); end
        n_checks++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL reset_inflight got %0d want 0", inflight_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_raw_bypass();
        long_op(5'd5);
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL raw_div_issue got %b want 1", issue_o); end
        tick();
        idle();
        dec_valid_i = 1'b1; rs1_addr_i = 5'd5; rs1_read_i = 1'b1;
        rs2_addr_i = 5'd1; rs2_read_i = 1'b1; rd_addr_i = 5'd6; reg_write_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall[%0d] got %b want 1", i, stall_o); end
            tick();
        end
        wb_valid_i = 1'b1; wb_addr_i = 5'd5;
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_issue got %b want 1", issue_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_bypass_stall got %b want 0", stall_o); end
        tick();
        idle();
        n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL raw_busy_after got %h want 0", busy_o); end
        n_checks++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL raw_inflight_after got %0d want 0", inflight_o); end
    endtask

    task automatic test_structural();
        for (int r = 1; r <= 4; r++) begin
            long_op(5'(r));
            #1;
            n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL struct_fill_issue[x%0d] got %b want 1", r, issue_o); end
            tick();
        end
        long_op(5'd7);
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL struct_full_stall got %b want 1", stall_o); end
        n_checks++; if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL struct_full_count got %0d want 4", inflight_o); end
        n_checks++; if (busy_o !== 32'h0000_001E) begin n_fail++; $display("FAIL struct_full_busy got %h want 0000001e", busy_o); end
        // Retiring x4 leaves x1..x3 busy, and the fifth op adds x7: 0x8E.
        wb_valid_i = 1'b1; wb_addr_i = 5'd4;
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL struct_wb_issue got %b want 1", issue_o); end
        tick();
        idle();
        n_checks++; if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL struct_after_count got %0d want 4", inflight_o); end
        n_checks++; if (busy_o !== 32'h0000_008E) begin n_fail++; $display("FAIL struct_after_busy got %h want 0000008e", busy_o); end
        writeback(5'd1); tick();
        writeback(5'd2); tick();
        writeback(5'd3); tick();
        writeback(5'd7); tick();
        idle();
        n_checks++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL struct_drained_count got %0d want 0", inflight_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL struct_err got %b want 0", err_o); end
    endtask

    task automatic test_x0();
        long_op(5'd0);
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL x0_issue got %b want 1", issue_o); end
        tick();
        idle();
        n_checks++; if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL x0_count got %0d want 1", inflight_o); end
        n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL x0_busy got %h want 0", busy_o); end
        writeback(5'd0);
        tick();
        idle();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL x0_err got %b want 1", err_o); end
        n_checks++; if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL x0_wb_count got %0d want 1", inflight_o); end
        tick();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL x0_err_sticky got %b want 1", err_o); end
        pulse_reset();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL x0_err_cleared got %b want 0", err_o); end
    endtask

    task automatic test_fence_drain();
        long_op(5'd10); tick();
        long_op(5'd11); tick();
        fence_instr();
        #1;
        n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL fence_first_ready got %b want 0", dec_ready_o); end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL fence_drain_ready[%0d] got %b want 0", i, dec_ready_o); end
            tick();
        end
        wb_valid_i = 1'b1; wb_addr_i = 5'd10;
        #1;
        n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL fence_wb1_ready got %b want 0", dec_ready_o); end
        tick();
        wb_addr_i = 5'd11;
        #1;
        n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL fence_wb2_ready got %b want 0", dec_ready_o); end
        tick();
        wb_valid_i = 1'b0;
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL fence_issue got %b want 1", issue_o); end
        n_checks++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL fence_count got %0d want 0", inflight_o); end
        tick();
        idle();
    endtask

    task automatic test_waw_same_cycle();
        long_op(5'd9); tick();
        long_op(5'd9);
        wb_valid_i = 1'b1; wb_addr_i = 5'd9;
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL same_cycle_issue got %b want 1", issue_o); end
        tick();
        idle();
        n_checks++; if (busy_o !== 32'h0000_0200) begin n_fail++; $display("FAIL same_cycle_busy got %h want 00000200", busy_o); end
        n_checks++; if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL same_cycle_count got %0d want 1", inflight_o); end
        long_op(5'd9);
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL waw_stall got %b want 1", stall_o); end
        writeback(5'd9); tick();
        idle();
        n_checks++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL waw_cleanup_count got %0d want 0", inflight_o); end
    endtask

    task automatic test_reset_drain();
        long_op(5'd1); tick();
        long_op(5'd2); tick();
        long_op(5'd3); tick();
        fence_instr(); tick();
        n_checks++; if (inflight_o !== 3'd3) begin n_fail++; $display("FAIL rdrain_count got %0d want 3", inflight_o); end
        #2 rst_i = 1'b0;
        #1;
        n_checks++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL rdrain_async_count got %0d want 0", inflight_o); end
        n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL rdrain_async_busy got %h want 0", busy_o); end
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rdrain_async_stall got %b want 1", stall_o); end
        n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL rdrain_async_ready got %b want 0", dec_ready_o); end
        tick();
        rst_i = 1'b1;
        tick();
        #1;
        n_checks++; if (issue_o !== 1'b1) begin n_fail++; $display("FAIL rdrain_run_fence_issue got %b want 1", issue_o); end
        tick();
        idle();
    endtask

    task automatic test_flush_drain();
        long_op(5'd4); tick();
        long_op(5'd5); tick();
        fence_instr(); tick();
        flush_i = 1'b1;
        #1;
        n_checks++; if (issue_o !== 1'b0) begin n_fail++; $display("FAIL flush_issue got %b want 0", issue_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall_o); end
        tick();
        idle();
        dec_valid_i = 1'b1; rs1_addr_i = 5'd8; rs1_read_i = 1'b1; rd_addr_i = 5'd12; reg_write_i = 1'b1;
        #1;
        n_checks++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_run_ready got %b want 1", dec_ready_o); end
        n_checks++; if (busy_o !== 32'h0000_0030) begin n_fail++; $display("FAIL flush_busy got %h want 00000030", busy_o); end
        n_checks++; if (inflight_o !== 3'd2) begin n_fail++; $display("FAIL flush_count got %0d want 2", inflight_o); end
        tick();
        writeback(5'd4); tick();
        writeback(5'd5); tick();
        idle();
        n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL flush_cleanup_busy got %h want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_raw_bypass();
        test_structural();
        test_x0();
        test_fence_drain();
        test_waw_same_cycle();
        test_reset_drain();
        test_flush_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
